// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: compare, target, BHT-based mispredict detection,
// registered redirect/exception pulses and saturating statistics counters.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic             ex_pred_taken,
    input  logic             stall,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             br_taken,
    output logic             illegal_br,
    output logic             misalign_exc,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    typedef enum logic [2:0] {
        F_BEQ  = 3'b000,
        F_BNE  = 3'b001,
        F_BLT  = 3'b100,
        F_BGE  = 3'b101,
        F_BLTU = 3'b110,
        F_BGEU = 3'b111
    } funct3_e;

    logic [1:0]      bht [BHT_ENTRIES];
    logic [IDX-1:0]  if_idx;
    logic [IDX-1:0]  ex_idx;
    logic            acc;
    logic            legal;
    logic            taken;
    logic            misalign;
    logic            redirect;
    logic            bht_update;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fallthrough;
    logic [1:0]      bht_cur;
    logic            unused_pc_bits;

    assign if_idx         = if_pc[IDX+1:2];
    assign ex_idx         = ex_pc[IDX+1:2];
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX+2], if_pc[1:0]};

    // Read is the registered array contents, so a same-cycle update is not bypassed.
    assign if_pred_taken = bht[if_idx][1];

    always_comb begin
        legal = 1'b1;
        taken = 1'b0;
        case (ex_funct3)
            F_BEQ:   taken = (ex_rs1 == ex_rs2);
            F_BNE:   taken = (ex_rs1 != ex_rs2);
            F_BLT:   taken = ($signed(ex_rs1) <  $signed(ex_rs2));
            F_BGE:   taken = ($signed(ex_rs1) >= $signed(ex_rs2));
            F_BLTU:  taken = (ex_rs1 <  ex_rs2);
            F_BGEU:  taken = (ex_rs1 >= ex_rs2);
            default: legal = 1'b0;
        endcase
    end

    assign acc         = ex_valid & ex_branch & ~stall;
    assign target      = ex_pc + ex_imm;
    assign fallthrough = ex_pc + XLEN'(4);
    assign misalign    = taken & (target[1:0] != 2'b00);
    assign redirect    = acc & legal & ~misalign & (taken ^ ex_pred_taken);
    assign bht_update  = acc & legal & ~misalign;
    assign bht_cur     = bht[ex_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid   <= 1'b0;
            flush            <= 1'b0;
            redirect_pc      <= '0;
            br_taken         <= 1'b0;
            illegal_br       <= 1'b0;
            misalign_exc     <= 1'b0;
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            redirect_valid <= redirect;
            flush          <= redirect;
            illegal_br     <= acc & ~legal;
            misalign_exc   <= acc & misalign;
            if (acc) begin
                br_taken <= taken;
            end
            if (redirect) begin
                redirect_pc <= taken ? target : fallthrough;
            end
            if (acc && legal && (stat_branches != '1)) begin
                stat_branches <= stat_branches + CNT_W'(1);
            end
            if (redirect && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table must come out of reset in a known state (weakly
            // not-taken), so unlike a plain RAM every entry is reset here.
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (bht_update) begin
            if (taken && (bht_cur != 2'b11)) begin
                bht[ex_idx] <= bht_cur + 2'b01;
            end else if (!taken && (bht_cur != 2'b00)) begin
                bht[ex_idx] <= bht_cur - 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed plan steps plus random
// branches compared against a behavioural model of the resolution rules.
module tb_branch_resolve_unit;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [XLEN-1:0]  if_pc;
    logic             if_pred_taken;
    logic             ex_valid;
    logic             ex_branch;
    logic [2:0]       ex_funct3;
    logic [XLEN-1:0]  ex_rs1;
    logic [XLEN-1:0]  ex_rs2;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_imm;
    logic             ex_pred_taken;
    logic             stall;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;
    logic             br_taken;
    logic             illegal_br;
    logic             misalign_exc;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispredicts;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          bht_m [ENTRIES];
    int          stb_m;
    int          stm_m;
    logic        e_rv;
    logic        e_taken;
    logic        e_ill;
    logic        e_mis;
    logic [31:0] e_rpc;

    branch_resolve_unit #(
        .XLEN(XLEN), .BHT_ENTRIES(ENTRIES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_pred_taken(ex_pred_taken), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .br_taken(br_taken), .illegal_br(illegal_br), .misalign_exc(misalign_exc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < ENTRIES; i++) bht_m[i] = 1;
        stb_m   = 0;
        stm_m   = 0;
        e_rv    = 1'b0;
        e_taken = 1'b0;
        e_ill   = 1'b0;
        e_mis   = 1'b0;
        e_rpc   = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".redirect_valid"},   64'(redirect_valid),   64'(e_rv));
        check({tag, ".flush"},            64'(flush),            64'(e_rv));
        check({tag, ".redirect_pc"},      64'(redirect_pc),      64'(e_rpc));
        check({tag, ".br_taken"},         64'(br_taken),         64'(e_taken));
        check({tag, ".illegal_br"},       64'(illegal_br),       64'(e_ill));
        check({tag, ".misalign_exc"},     64'(misalign_exc),     64'(e_mis));
        check({tag, ".stat_branches"},    64'(stat_branches),    64'(stb_m));
        check({tag, ".stat_mispredicts"}, 64'(stat_mispredicts), 64'(stm_m));
    endtask

    function automatic int table_index(input logic [31:0] pc);
        return int'(pc / 4) % ENTRIES;
    endfunction

    // One clock: drive, check the fetch prediction before the edge, advance the
    // model, then check the registered outputs just after the edge.
    task automatic step(input string tag, input logic v, input logic br,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc,
                        input logic [31:0] imm, input logic pred,
                        input logic st, input logic [31:0] ifpc);
        logic        acc;
        logic        legal;
        logic        tk;
        logic        mis;
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] ft;
        int          ei;
        ex_valid      = v;
        ex_branch     = br;
        ex_funct3     = f3;
        ex_rs1        = a;
        ex_rs2        = b;
        ex_pc         = pc;
        ex_imm        = imm;
        ex_pred_taken = pred;
        stall         = st;
        if_pc         = ifpc;
        #1;
        check({tag, ".if_pred_taken"}, 64'(if_pred_taken),
              64'(bht_m[table_index(ifpc)] >= 2));
        acc   = v && br && !st;
        legal = !(f3 == 3'd2 || f3 == 3'd3);
        case (f3)
            3'd0:    tk = (a == b);
            3'd1:    tk = (a != b);
            3'd4:    tk = ($signed(a) < $signed(b));
            3'd5:    tk = !($signed(a) < $signed(b));
            3'd6:    tk = (a < b);
            3'd7:    tk = !(a < b);
            default: tk = 1'b0;
        endcase
        tgt   = pc + imm;
        ft    = pc + 32'd4;
        mis   = tk && (tgt % 4 != 0);
        redir = acc && legal && !mis && (tk != pred);
        e_rv  = redir;
        e_ill = acc && !legal;
        e_mis = acc && mis;
        if (acc) e_taken = tk;
        if (redir) e_rpc = tk ? tgt : ft;
        if (acc && legal && stb_m < CNT_MAX) stb_m++;
        if (redir && stm_m < CNT_MAX) stm_m++;
        if (acc && legal && !mis) begin
            ei = table_index(pc);
            if (tk && bht_m[ei] < 3) bht_m[ei]++;
            if (!tk && bht_m[ei] > 0) bht_m[ei]--;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input logic [31:0] ifpc);
        step(tag, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 1'b0, ifpc);
    endtask

    initial begin
        logic [31:0] r;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        rst_n = 1'b0;
        ex_valid = 0; ex_branch = 0; ex_funct3 = 0; ex_rs1 = 0; ex_rs2 = 0;
        ex_pc = 0; ex_imm = 0; ex_pred_taken = 0; stall = 0; if_pc = 32'h40;
        reset_model();
        #12;
        check_outputs("reset");
        check("reset.if_pred_taken", 64'(if_pred_taken), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Plan: BEQ mispredict, then pulses clear
        step("beq_redirect", 1, 1, 3'd0, 5, 5, 32'h100, 32'h20, 0, 0, 32'h100);
        check("beq_redirect.pc_literal", 64'(redirect_pc), 64'h120);
        idle("beq_pulse_clear", 32'h100);

        // Signed vs unsigned compare
        step("blt_signed", 1, 1, 3'd4, 32'hFFFF_FFFF, 1, 32'h200, 32'h40, 1, 0, 32'h200);
        step("bltu_unsigned", 1, 1, 3'd6, 32'hFFFF_FFFF, 1, 32'h200, 32'h40, 1, 0, 32'h200);
        check("bltu_unsigned.pc_literal", 64'(redirect_pc), 64'h204);

        // BHT training at pc 0x40 (index 16), fetch reading the same index
        step("bht_1", 1, 1, 3'd0, 7, 7, 32'h40, 32'h10, 0, 0, 32'h40);
        step("bht_2", 1, 1, 3'd0, 7, 7, 32'h40, 32'h10, 1, 0, 32'h40);
        step("bht_3", 1, 1, 3'd0, 7, 7, 32'h40, 32'h10, 1, 0, 32'h40);
        idle("bht_read", 32'h40);

        // Address wrap and misalignment
        step("wrap", 1, 1, 3'd1, 1, 2, 32'hFFFF_FFF0, 32'h20, 0, 0, 32'h0);
        check("wrap.pc_literal", 64'(redirect_pc), 64'h10);
        step("misalign", 1, 1, 3'd0, 3, 3, 32'h80, 32'h22, 0, 0, 32'h80);
        idle("misalign_bht", 32'h80);

        // Illegal funct3
        step("illegal", 1, 1, 3'd2, 3, 3, 32'h90, 32'h20, 0, 0, 32'h90);
        idle("illegal_clear", 32'h90);

        // Stall held for three cycles, then accepted
        for (int i = 0; i < 3; i++)
            step($sformatf("stall_%0d", i), 1, 1, 3'd0, 9, 9, 32'h300, 32'h8, 0, 1, 32'h300);
        step("unstall", 1, 1, 3'd0, 9, 9, 32'h300, 32'h8, 0, 0, 32'h300);

        // Back-to-back mispredicts with distinct targets
        step("b2b_1", 1, 1, 3'd5, 4, 4, 32'h400, 32'h100, 0, 0, 32'h400);
        step("b2b_2", 1, 1, 3'd7, 0, 4, 32'h500, 32'h100, 1, 0, 32'h500);

        // Random traffic (counters are narrow, so saturation is exercised)
        for (int i = 0; i < 400; i++) begin
            r  = $urandom;
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 3))
                                             : 3'(r[2:0] | {r[1], 2'b00} | {1'b0, 1'b0, 1'b0});
            if (f3 == 3'd2 || f3 == 3'd3) f3 = ($urandom_range(0, 9) == 0) ? f3 : 3'd0;
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? a : (($urandom_range(0, 1) == 1) ? $urandom : a - 1);
            step($sformatf("rand_%0d", i), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 7) != 0), f3, a, b, $urandom & 32'h3FC,
                 {{20{r[31]}}, r[30:20], 1'b0}, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0), $urandom & 32'h3FC);
        end

        // Asynchronous reset while a redirect pulse is high
        step("pre_reset", 1, 1, 3'd0, 5, 5, 32'h40, 32'h20, 0, 0, 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        reset_model();
        check_outputs("async_reset");
        for (int i = 0; i < 4; i++) begin
            if_pc = 32'(i * 52);
            #1;
            check($sformatf("async_reset.bht_%0d", i), 64'(if_pred_taken), 64'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", 1, 1, 3'd0, 1, 1, 32'h40, 32'h20, 0, 0, 32'h40);
        idle("post_reset_bht", 32'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
